// File: rtl/zpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zpu_mem_pkg
// Purpose  : Shared encodings for the ZPU internal RAM master: access-size
//            codes, the controller state enum and the default word width.
// Revision : 1.0 - initial release
// ============================================================================
package zpu_mem_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Access size encodings; 2'b11 is handled as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_WR        = 3'd2,
    ST_RMW_RD    = 3'd3,
    ST_RMW_MERGE = 3'd4,
    ST_RMW_WR    = 3'd5,
    ST_RSP       = 3'd6
  } mem_state_t;

endpackage : zpu_mem_pkg
`default_nettype wire

// File: rtl/zpu_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : zpu_lane_merge
// Purpose  : Big-endian byte/halfword lane handling for a 32-bit word.
//            Extracts the addressed lane (zero-extended) and builds the word
//            with the addressed lane replaced by right-justified write data.
// Revision : 1.0 - initial release
// ============================================================================
module zpu_lane_merge
  import zpu_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] lane_data,
  output logic [31:0] merged
);

  logic [31:0] lane_mask;
  logic [4:0]  lane_shift;

  // Lane position: byte k sits at bit 8*(3-k), halfword 0 sits at bit 16.
  always_comb begin
    lane_mask  = 32'hFFFF_FFFF;
    lane_shift = 5'd0;
    case (size)
      SIZE_BYTE: begin
        lane_mask  = 32'h0000_00FF;
        lane_shift = {~offset, 3'b000};
      end
      SIZE_HALF: begin
        lane_mask  = 32'h0000_FFFF;
        lane_shift = {~offset[1], 4'b0000};
      end
      default: begin
        lane_mask  = 32'hFFFF_FFFF;
        lane_shift = 5'd0;
      end
    endcase
  end

  // Extraction and insertion share the same mask/shift pair.
  always_comb begin
    lane_data = (word >> lane_shift) & lane_mask;
    merged    = (word & ~(lane_mask << lane_shift))
              | ((wdata & lane_mask) << lane_shift);
  end

endmodule : zpu_lane_merge
`default_nettype wire

// File: rtl/internal_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : internal_ram_master
// Purpose  : ZPU-side initiator for the single-port internal RAM. Accepts
//            load/store requests, absorbs the RAM's one-cycle read latency
//            and performs read-modify-write for sub-word stores.
// Config   : ZPU_MEM_SUBWORD_EN - when defined, byte/halfword accesses are
//            supported; otherwise every access is a whole-word access.
// Revision : 1.0 - initial release
// ============================================================================
module internal_ram_master
  import zpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write_en,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  mem_state_t state;
  mem_state_t next_state;

  // Held request attributes; ram_addr itself holds the word address.
  logic hold_we;

`ifdef ZPU_MEM_SUBWORD_EN
  logic [1:0]            hold_size;
  logic [1:0]            hold_off;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  is_word_req;

  // Sizes 10 and 11 both count as whole-word.
  assign is_word_req = req_size[1];

  // The same lane unit serves the load return path and the RMW merge;
  // ram_dout holds the addressed word in both RSP and RMW_MERGE.
  zpu_lane_merge u_lane_merge (
    .size      (hold_size),
    .offset    (hold_off),
    .word      (ram_dout),
    .wdata     (hold_wdata),
    .lane_data (lane_data),
    .merged    (merged_word)
  );
`else
  logic [DATA_WIDTH-1:0] lane_data;
  logic                  unused_subword;

  // Whole-word only: size and byte offset carry no meaning here.
  assign lane_data      = ram_dout;
  assign unused_subword = ^{req_size, req_addr[1:0]};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_we) begin
            next_state = ST_RD;
          end else begin
`ifdef ZPU_MEM_SUBWORD_EN
            next_state = is_word_req ? ST_WR : ST_RMW_RD;
`else
            next_state = ST_WR;
`endif
          end
        end
      end
      ST_RD:        next_state = ST_RSP;
      ST_WR:        next_state = ST_RSP;
`ifdef ZPU_MEM_SUBWORD_EN
      ST_RMW_RD:    next_state = ST_RMW_MERGE;
      ST_RMW_MERGE: next_state = ST_RMW_WR;
      ST_RMW_WR:    next_state = ST_RSP;
`endif
      ST_RSP:       next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Handshake and response outputs decoded from state.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RSP);
    rsp_rdata = '0;
    if ((state == ST_RSP) && !hold_we) begin
      rsp_rdata = lane_data;
    end
  end

  // RAM-side registers and held request fields; ram_addr only moves on
  // accept so ram_dout remains the addressed word through RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr     <= '0;
      ram_write_en <= 1'b0;
      ram_din      <= '0;
      hold_we      <= 1'b0;
`ifdef ZPU_MEM_SUBWORD_EN
      hold_size    <= '0;
      hold_off     <= '0;
      hold_wdata   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ram_addr     <= req_addr[ADDR_WIDTH+1:2];
            hold_we      <= req_we;
            ram_write_en <= 1'b0;
`ifdef ZPU_MEM_SUBWORD_EN
            hold_size    <= req_size;
            hold_off     <= req_addr[1:0];
            hold_wdata   <= req_wdata;
            if (req_we && is_word_req) begin
              ram_din      <= req_wdata;
              ram_write_en <= 1'b1;
            end
`else
            if (req_we) begin
              ram_din      <= req_wdata;
              ram_write_en <= 1'b1;
            end
`endif
          end
        end
        ST_WR: begin
          ram_write_en <= 1'b0;
        end
`ifdef ZPU_MEM_SUBWORD_EN
        ST_RMW_MERGE: begin
          ram_din      <= merged_word;
          ram_write_en <= 1'b1;
        end
        ST_RMW_WR: begin
          ram_write_en <= 1'b0;
        end
`endif
        default: begin
          ram_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule : internal_ram_master
`default_nettype wire

// File: doc/internal_ram_master.md
# internal_ram_master

Initiator side of the single-port internal RAM interface. Accepts byte, halfword and word load/store requests from the ZPU core over a valid/ready handshake and drives the RAM's address, write-enable and write-data lines. Absorbs the RAM's one-cycle registered read latency and performs read-modify-write for sub-word stores, because the RAM has only a whole-word write enable. Sits between the ZPU core's memory port and the 512x32 internal RAM.

## Interface
- ADDR_WIDTH, 9: RAM word-address width. The request byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32: word width. Fixed at 32 for lane logic.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE. A request is accepted at an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word. 11 is treated as word.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- rsp_valid  out  1  one-cycle pulse per accepted request. Has no back-pressure.
- rsp_rdata  out  32  load data, zero-extended. Value is 0 for stores.
- ram_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2]. Registered.
- ram_write_en  out  1  registered.
- ram_din  out  32  registered.
- ram_dout  in  32  RAM registered output. Valid the cycle after ram_addr is presented. Returns old data on a write cycle.

## Operation
- Lanes are big-endian:
  - byte at addr[1:0]=0 is bits 31:24; addr[1:0]=3 is bits 7:0.
  - halfword at addr[1]=0 is bits 31:16.
  - addr[0] is ignored for halfwords (aligned down). addr[1:0] is ignored for words.
- States: IDLE, RD, WR, RMW_RD, RMW_MERGE, RMW_WR, RSP.
- IDLE, on accept:
  - load → RD; ram_addr is loaded, ram_write_en<=0.
  - word store → WR; ram_addr and ram_din<=req_wdata are loaded, ram_write_en<=1.
  - sub-word store → RMW_RD; ram_addr is loaded, ram_write_en<=0.
  - size, lane offset and wdata are held in registers.
- RD → RSP. WR → RSP, with ram_write_en<=0 at the transition.
- RMW_RD → RMW_MERGE. In RMW_MERGE, ram_dout holds the old word. On exit: ram_din<=old word with the addressed lane replaced, ram_write_en<=1, next state RMW_WR.
- RMW_WR → RSP, with ram_write_en<=0.
- RSP:
  - rsp_valid=1.
  - rsp_rdata = lane extracted from ram_dout for loads, 0 for stores.
  - next state IDLE.
- req_valid while req_ready=0: the request is not accepted. The requester must hold it.
- Reset (async, any state):
  - state IDLE; ram_write_en, ram_addr, ram_din and held registers go to 0 immediately.
  - the in-flight request is dropped with no rsp_valid. A pending RMW never writes.
- ram_addr changes only on accept, so ram_dout stays stable through RSP.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, ram_write_en=0, ram_addr=0, ram_din=0.
- E0 = accept edge.
- Load or word store:
  - word store commits at E1.
  - rsp_valid is high E1–E2.
  - IDLE and req_ready=1 again from E2, so throughput is one access per 2 cycles.
- Sub-word store:
  - ram_write_en is high E2–E3; commits at E3.
  - rsp_valid is high E3–E4.
  - req_ready=1 from E4.
- req_ready and rsp_valid are decoded combinationally from state. All RAM-side outputs come directly from registers.

## Configuration
- ZPU_MEM_SUBWORD_EN defined:
  - full behaviour as above.
- Not defined:
  - req_size is ignored; all accesses are whole-word.
  - RMW_RD, RMW_MERGE and RMW_WR are not built.
  - loads return the full ram_dout word.

## Structure
- Shared package zpu_mem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - the state enum.
  - the DATA_WIDTH default.
- One natural sub-module: zpu_lane_merge, purely combinational. It covers:
  - lane extraction: size, offset, word → zero-extended data.
  - lane insertion: size, offset, old word, wdata → merged word.
  - it is shared by the load path and the RMW path.

## Test plan
- Reset: hold rst_n low for 3 cycles with req_valid=1 → all outputs at reset values and no RAM write. After release, req_ready=1.
- Word store 0xDEADBEEF at 0x010, then word load 0x010:
  - store: ram_write_en high exactly E0–E1, ram_addr=0x004.
  - load: rsp_valid high E1–E2, rsp_rdata=0xDEADBEEF.
- Word store 0x11223344 at 0x010, then byte store 0xA5 at 0x012:
  - single ram_write_en pulse, high E2–E3, with ram_din=0x1122A544.
  - rsp_valid high E3–E4.
  - word load returns 0x1122A544.
- Halfword load at 0x012, then at 0x013 → both give 0x0000A544. Byte load at 0x011 → 0x00000022.
- Reset pulse during RMW_MERGE of byte store 0xFF at 0x010 → ram_write_en never rises and no rsp_valid. A following word load returns 0x1122A544.
- req_valid held high for two word loads → accepts at E0 and E2, req_ready low E0–E2, two rsp_valid pulses (E1–E2, E3–E4).
